i2s_dac_transmitter: RTL
========================

# i2s_dac_transmitter

Master-mode I2S transmitter that drives an external stereo audio DAC: the opposite direction of the external ADC receive path (bclk/lrclk/dout). It takes left/right sample pairs from the audio pipeline over a stb/ack handshake. It generates bit clock, word select and serial data in Philips I2S format. A one-pair holding register decouples the producer from frame timing, and an underrun flag reports missed frames.

## Interface

- DIVIDER, 8, clk cycles per bclk half-period; minimum 1. At a 50 MHz clk this gives bclk = 3.125 MHz and fs = 48.83 kHz with SLOT = 32.
- WIDTH, 16, sample bits per channel; two's complement; WIDTH <= SLOT.
- SLOT, 32, bclk periods per channel slot; a frame is 2*SLOT bclk periods.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- left_in  input  WIDTH  left sample; held stable by the producer while sample_stb_in is high.
- right_in  input  WIDTH  right sample; same rule as left_in.
- sample_stb_in  input  1  producer has a valid pair; held high until acknowledged.
- sample_ack_out  output  1  one-cycle pulse; the pair is captured on the clk edge ending the pulse.
- bclk_out  output  1  I2S bit clock.
- lrclk_out  output  1  word select; 0 = left, 1 = right.
- dout_out  output  1  serial data, MSB first.
- underrun_out  output  1  one-cycle pulse when a frame starts with no pair in the holding register.

## Operation

**Bit-clock divider**
- div_cnt counts 0..DIVIDER-1.
- When div_cnt = DIVIDER-1, div_cnt wraps to 0 and bclk_out toggles.
- A 1->0 toggle is a "falling event".

**Bit index**
- b counts 0..2*SLOT-1 and advances on each falling event, wrapping from 2*SLOT-1 to 0.
- b = 0 is the "frame load" event.

**Driven on each falling event, for the new value of b**
- lrclk_out = 1 when SLOT-1 <= b <= 2*SLOT-2; otherwise 0. Word select therefore changes one bit before the MSB.
- dout_out for b in 0..WIDTH-1: left bit WIDTH-1-b.
- dout_out for b in WIDTH..SLOT-1: 0.
- dout_out for b in SLOT..SLOT+WIDTH-1: right bit WIDTH-1-(b-SLOT).
- dout_out for the remaining b: 0.

**Frame load**
- The shift register (2*SLOT bits) is loaded from the holding register and the holding register is marked empty.
- If the holding register is empty, the shift register is loaded with zeros and underrun_out pulses for that clk cycle.

**Handshake**
- Cycle N: sample_stb_in = 1, holding register empty, and sample_ack_out = 0. Then sample_ack_out = 1 in cycle N+1.
- On the edge ending cycle N+1, left_in/right_in are captured and the holding register becomes full.
- sample_ack_out is never high for two consecutive cycles.
- While the holding register is full, sample_stb_in is ignored; no ack is issued.

**Simultaneous events**
- A frame load in the same cycle as a capture: the frame takes the previous holding state. If that state was empty, the frame is an underrun and the captured pair goes to the next frame.
- Frame load frees the holding register, so an ack may follow in the next cycle.

## Timing

**Reset values**
- bclk_out = 0, lrclk_out = 0, dout_out = 0, sample_ack_out = 0, underrun_out = 0.
- div_cnt = 0, b = 2*SLOT-1, holding register empty, shift register all zeros.

**After reset release**
- The first rising bclk edge occurs at clk cycle DIVIDER.
- The first falling event (the first frame load) occurs at cycle 2*DIVIDER.

**Output alignment and duration**
- dout_out and lrclk_out change only in the same clk cycle as a bclk falling event, so they are stable around every rising edge.
- bclk period = 2*DIVIDER clk cycles; frame = 4*SLOT*DIVIDER clk cycles.

**Latency and throughput**
- Stb-to-ack latency is 1 cycle when the holding register is empty.
- A pair acknowledged before a frame load appears at dout_out starting at that load; its left MSB is at b = 0.
- Sustained throughput is one pair per frame.

**Reset mid-frame**
- All state returns to reset values immediately (asynchronous reset).
- A pending pair is discarded; the producer keeps stb high and receives an ack after reset is released.

## Test plan

- **Reset behaviour:** DIVIDER=2, SLOT=32, WIDTH=16; release rst with no stb -> bclk first rises at cycle 2; every frame is all-zero dout; underrun_out pulses at each frame load, every 256 cycles.
- **Single-pair bit order:** present left=0x8001, right=0x7FFE -> ack 1 cycle after stb. The next frame's dout sampled on rising bclk edges is 1,0×14,1, then 16 zeros, then 0,1×14,0, then 16 zeros. lrclk is 0 for b = 63 and b = 0..30, and 1 for b = 31..62.
- **Back-pressure:** keep stb high continuously with new data after each ack -> exactly one ack per frame, no underrun, and consecutive frames carry consecutive pairs.
- **Simultaneous load and capture:** time stb so the ack cycle coincides with the frame load while the holding register is empty -> underrun pulse for that frame; the pair is transmitted in the following frame.
- **Reset mid-frame:** assert rst at b = 40 -> all outputs 0 in the same cycle, and the sequence restarts as in the first scenario.
- **Parameter sweep:** DIVIDER=1, WIDTH=24, SLOT=24 -> bclk toggles every cycle, and dout carries 24 data bits per slot with no padding.

Source files
------------

// File: rtl/i2s_dac_transmitter.sv
// i2s_dac_transmitter
// Master-mode Philips I2S transmitter for an external stereo DAC. It generates
// the bit clock and word select, serialises left/right pairs MSB first, and
// decouples the producer from frame timing through a one-pair holding register.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   left_in        left sample (two's complement, WIDTH bits)
//   right_in       right sample (two's complement, WIDTH bits)
//   sample_stb_in  producer has a valid pair; held until acknowledged
//   sample_ack_out one-cycle pulse; pair captured on the edge ending the pulse
//   bclk_out       I2S bit clock (half-period = DIVIDER clk cycles)
//   lrclk_out      word select, 0 = left, 1 = right
//   dout_out       serial data, MSB first, changes with the bclk falling edge
//   underrun_out   one-cycle pulse when a frame starts with no pair available
module i2s_dac_transmitter #(
    parameter int DIVIDER = 8,
    parameter int WIDTH   = 16,
    parameter int SLOT    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    input  logic             sample_stb_in,
    output logic             sample_ack_out,
    output logic             bclk_out,
    output logic             lrclk_out,
    output logic             dout_out,
    output logic             underrun_out
);

    localparam int FRAME_BITS = 2 * SLOT;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int DW         = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] LR_FIRST = BW'(SLOT - 1);
    localparam logic [BW-1:0] LR_LAST  = BW'(FRAME_BITS - 2);

    logic [DW-1:0]         div_cnt_q, div_cnt_d;
    logic                  bclk_q, bclk_d;
    logic [BW-1:0]         b_q, b_d;
    logic                  lrclk_q, lrclk_d;
    logic                  dout_q, dout_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  hold_full_q, hold_full_d;
    logic [WIDTH-1:0]      hold_left_q, hold_left_d;
    logic [WIDTH-1:0]      hold_right_q, hold_right_d;
    logic                  ack_q, ack_d;
    logic                  underrun_q, underrun_d;

    logic                  bit_tick;
    logic                  fall_event;
    logic                  frame_load;
    logic [BW-1:0]         b_next;
    logic [FRAME_BITS-1:0] left_ext;
    logic [FRAME_BITS-1:0] right_ext;
    logic [FRAME_BITS-1:0] load_word;

    // Timing events: bclk toggles when the divider wraps; a falling toggle
    // advances the bit index, and the wrap of the index to 0 is the frame load.
    always_comb begin
        bit_tick   = (div_cnt_q == DIV_LAST);
        fall_event = bit_tick && bclk_q;
        b_next     = (b_q == B_LAST) ? '0 : b_q + BW'(1);
        frame_load = fall_event && (b_q == B_LAST);
    end

    // Frame image: left word at the top of the left slot, right word at the
    // top of the right slot, zero padding below each. An empty holding
    // register yields an all-zero frame.
    always_comb begin
        left_ext                = '0;
        right_ext               = '0;
        left_ext[WIDTH-1:0]     = hold_left_q;
        right_ext[WIDTH-1:0]    = hold_right_q;
        load_word               = '0;
        if (hold_full_q) begin
            load_word = (left_ext << (FRAME_BITS - WIDTH)) | (right_ext << (SLOT - WIDTH));
        end
    end

    // Bit clock divider and serialiser. dout and lrclk only move on a falling
    // event so they are stable around every rising bclk edge.
    always_comb begin
        div_cnt_d  = bit_tick ? '0 : div_cnt_q + DW'(1);
        bclk_d     = bit_tick ? ~bclk_q : bclk_q;
        b_d        = b_q;
        lrclk_d    = lrclk_q;
        dout_d     = dout_q;
        shift_d    = shift_q;
        underrun_d = frame_load && !hold_full_q;
        if (fall_event) begin
            b_d     = b_next;
            lrclk_d = (b_next >= LR_FIRST) && (b_next <= LR_LAST);
            if (frame_load) begin
                dout_d  = load_word[FRAME_BITS-1];
                shift_d = {load_word[FRAME_BITS-2:0], 1'b0};
            end else begin
                dout_d  = shift_q[FRAME_BITS-1];
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    // Handshake and holding register. A frame load empties the register using
    // its previous state; a capture on the same edge refills it afterwards, so
    // that pair waits for the following frame.
    always_comb begin
        ack_d        = sample_stb_in && !hold_full_q && !ack_q;
        hold_full_d  = hold_full_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        if (frame_load) begin
            hold_full_d = 1'b0;
        end
        if (ack_q) begin
            hold_full_d  = 1'b1;
            hold_left_d  = left_in;
            hold_right_d = right_in;
        end
    end

    // State register; the bit index resets to the last position so the first
    // falling event produces the first frame load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            bclk_q       <= 1'b0;
            b_q          <= B_LAST;
            lrclk_q      <= 1'b0;
            dout_q       <= 1'b0;
            shift_q      <= '0;
            hold_full_q  <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            ack_q        <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bclk_q       <= bclk_d;
            b_q          <= b_d;
            lrclk_q      <= lrclk_d;
            dout_q       <= dout_d;
            shift_q      <= shift_d;
            hold_full_q  <= hold_full_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            ack_q        <= ack_d;
            underrun_q   <= underrun_d;
        end
    end

    assign sample_ack_out = ack_q;
    assign bclk_out       = bclk_q;
    assign lrclk_out      = lrclk_q;
    assign dout_out       = dout_q;
    assign underrun_out   = underrun_q;

endmodule
